// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM burst controller: FSM state encoding and
// address-width derivation from the RAM depth.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrite   = 3'd1,
    StRdIssue = 3'd2,
    StRdWait  = 3'd3,
    StRdHold  = 3'd4
  } ctrl_state_e;

  // A single-word RAM still needs a one-bit address port.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_burst_controller.sv
// Burst sequencer mastering a single-port RAM: expands one command into
// word-by-word accesses at consecutive (wrapping) addresses.
module ram_burst_controller
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned AW        = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [AW-1:0]         cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  done,
  output logic                  ram_enable,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] ram_write_mask,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_busy
);

  localparam logic [AW-1:0] AddrOne = AW'(1);
  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);

  ctrl_state_e           state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  // Remaining beats; one extra bit so a full-depth burst fits.
  logic [AW:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  last_beat;
  logic                  wr_beat;

  assign last_beat = (cnt_q == CntOne);
  assign rdata     = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    mask_d         = mask_q;
    rdata_d        = rdata_q;
    wr_beat        = 1'b0;
    cmd_ready      = 1'b0;
    wdata_ready    = 1'b0;
    rdata_valid    = 1'b0;
    rdata_last     = 1'b0;
    done           = 1'b0;
    ram_enable     = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = '0;
    ram_data_in    = '0;
    ram_write_mask = '0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = {1'b0, cmd_len} + CntOne;
          mask_d  = cmd_mask;
          state_d = cmd_write ? StWrite : StRdIssue;
        end
      end

      StWrite: begin
        wdata_ready = !ram_busy;
        wr_beat     = wdata_valid && !ram_busy;
        ram_enable  = wr_beat;
        ram_we      = wr_beat;
        ram_addr    = addr_q;
        if (wr_beat) begin
          ram_data_in    = wdata;
          ram_write_mask = mask_q;
          addr_d         = addr_q + AddrOne;
          cnt_d          = cnt_q - CntOne;
          if (last_beat) begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end
      end

      StRdIssue: begin
        if (!ram_busy) begin
          ram_enable = 1'b1;
          ram_addr   = addr_q;
          state_d    = StRdWait;
        end
      end

      // RAM output is registered: data for the issued read is visible now.
      StRdWait: begin
        rdata_d = ram_data_out;
        state_d = StRdHold;
      end

      StRdHold: begin
        rdata_valid = 1'b1;
        rdata_last  = last_beat;
        if (rdata_ready) begin
          addr_d = addr_q + AddrOne;
          cnt_d  = cnt_q - CntOne;
          if (last_beat) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRdIssue;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ram_burst_controller.sv
// Scoreboard bench for ram_burst_controller: a behavioural memory model
// predicts every RAM write, read address and returned read beat.
module tb_ram_burst_controller;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          wdata_valid = 1'b0, wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          rdata_valid, rdata_ready = 1'b1, rdata_last, done;
  logic [DW-1:0] rdata;
  logic          ram_enable, ram_we, ram_busy = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in, ram_write_mask;
  logic [DW-1:0] ram_data_out = '0;
  logic [DW-1:0] ram_mem [DEPTH] = '{default: 8'h00};

  ram_burst_controller #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_mask(cmd_mask),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .done(done),
    .ram_enable(ram_enable), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_write_mask(ram_write_mask),
    .ram_data_out(ram_data_out), .ram_busy(ram_busy)
  );

  always #5 clk = ~clk;

  // Bench-side RAM with registered read data and bitwise write mask.
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_we)
        ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_write_mask) | (ram_data_in & ram_write_mask);
      else
        ram_data_out <= ram_mem[ram_addr];
    end
  end

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data; logic [DW-1:0] mask;} wr_exp_t;
  typedef struct {logic [DW-1:0] data; logic last;} rd_exp_t;

  logic [DW-1:0] model_mem [DEPTH];
  wr_exp_t       exp_wr_q[$];
  logic [AW-1:0] exp_rd_addr_q[$];
  rd_exp_t       exp_rd_q[$];
  logic [DW-1:0] beat_data[$];

  int n_checks = 0, n_errors = 0;
  int done_seen = 0, n_cmds = 0, n_access = 0;
  int hold_cnt = 0;
  bit busy_mode = 0, rand_ready = 0, gaps = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an access or beat.
  initial begin : monitor
    wr_exp_t       we_e;
    rd_exp_t       rd_e;
    logic [AW-1:0] ra;
    bit            prev_hold = 0, in_burst = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 0;
        in_burst  = 0;
      end else begin
        if (ram_busy) begin
          check("no_access_while_busy", ram_enable, 0);
          check("wdata_ready_while_busy", wdata_ready, 0);
        end
        if (ram_enable) n_access++;
        if (ram_enable && ram_we) begin
          if (exp_wr_q.size() == 0) check("unexpected_write", 1, 0);
          else begin
            we_e = exp_wr_q.pop_front();
            check("wr_addr", ram_addr, we_e.addr);
            check("wr_data", ram_data_in, we_e.data);
            check("wr_mask", ram_write_mask, we_e.mask);
          end
        end else if (ram_enable) begin
          if (exp_rd_addr_q.size() == 0) check("unexpected_read", 1, 0);
          else begin
            ra = exp_rd_addr_q.pop_front();
            check("rd_addr", ram_addr, ra);
          end
          check("rd_zero_data_mask", {ram_data_in, ram_write_mask}, 0);
        end
        if (prev_hold)
          check("rdata_stable", {rdata_valid, rdata_last, rdata}, {1'b1, prev_last, prev_data});
        if (rdata_valid && rdata_ready) begin
          if (exp_rd_q.size() == 0) check("unexpected_rbeat", 1, 0);
          else begin
            rd_e = exp_rd_q.pop_front();
            check("rdata", rdata, rd_e.data);
            check("rdata_last", rdata_last, rd_e.last);
          end
        end
        prev_hold = rdata_valid && !rdata_ready;
        prev_data = rdata;
        prev_last = rdata_last;
        if (in_burst) check("cmd_ready_low_in_burst", cmd_ready, 0);
        if (done) begin
          done_seen++;
          in_burst = 0;
        end
        if (cmd_valid && cmd_ready) in_burst = 1;
      end
    end
  end

  initial begin : busy_gen
    forever begin
      @(posedge clk);
      #1;
      if (busy_mode) ram_busy = ($urandom_range(3) == 0);
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rdata_valid && hold_cnt > 0) begin
        rdata_ready = 1'b0;
        hold_cnt--;
      end else begin
        rdata_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      end
    end
  end

  task automatic cmd_handshake(input bit wr, input int unsigned addr, input int unsigned len,
                               input logic [DW-1:0] mask);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = AW'(len);
    cmd_mask  = mask;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    check("cmd_accept", ok, 1);
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
  endtask

  task automatic drive_beat(input logic [DW-1:0] d);
    bit ok = 0;
    if (gaps && $urandom_range(3) == 0) begin
      wdata_valid = 1'b0;
      wdata       = DW'($urandom);
      @(posedge clk);
      #1;
    end
    wdata_valid = 1'b1;
    wdata       = d;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      ok = wdata_ready;
      @(posedge clk);
      #1;
    end
    check("wbeat_accept", ok, 1);
    wdata_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int n = 0; n < 3000 && done_seen < target; n++) @(negedge clk);
    check("done_seen", done_seen >= target, 1);
    @(posedge clk);
    #1;
  endtask

  // Reference: apply the whole burst to model_mem, queue expected traffic.
  task automatic run_burst(input bit wr, input int unsigned addr, input int unsigned len,
                           input logic [DW-1:0] mask);
    logic [DW-1:0] d[$];
    logic [DW-1:0] dv;
    logic [AW-1:0] a;
    int            target;
    target = done_seen + 1;
    for (int i = 0; i <= int'(len); i++) begin
      a = AW'((addr + i) % DEPTH);
      if (wr) begin
        dv = (i < beat_data.size()) ? beat_data[i] : DW'($urandom);
        d.push_back(dv);
        model_mem[a] = (model_mem[a] & ~mask) | (dv & mask);
        exp_wr_q.push_back('{addr: a, data: dv, mask: mask});
      end else begin
        exp_rd_addr_q.push_back(a);
        exp_rd_q.push_back('{data: model_mem[a], last: (i == int'(len))});
      end
    end
    beat_data.delete();
    cmd_handshake(wr, addr, len, wr ? mask : DW'($urandom));
    if (wr) foreach (d[i]) drive_beat(d[i]);
    wait_done(target);
    n_cmds++;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {cmd_ready, wdata_ready, rdata_valid, rdata_last, done, ram_enable, ram_we,
                 ram_addr, ram_data_in, ram_write_mask, rdata},
          {1'b1, 6'b0, 4'b0, 24'b0});
  endtask

  initial begin : main
    int a0;
    int d0;
    foreach (model_mem[i]) model_mem[i] = '0;
    #1;
    check_reset_outputs("reset_outputs");
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain 5-beat write of FF.
    repeat (5) beat_data.push_back(8'hFF);
    a0 = n_access;
    run_burst(1, 0, 4, 8'hFF);
    check("write5_accesses", n_access - a0, 5);

    // Single-word writes then a backpressured single-beat read.
    beat_data.push_back(8'hAA);
    run_burst(1, 5, 0, 8'hFF);
    beat_data.push_back(8'h55);
    run_burst(1, 10, 0, 8'hFF);
    hold_cnt = 4;
    run_burst(0, 5, 0, 8'h00);
    run_burst(0, 10, 0, 8'h00);

    // Address wrap-around.
    foreach (beat_data[i]) beat_data.delete();
    beat_data.push_back(8'h01); beat_data.push_back(8'h02);
    beat_data.push_back(8'h03); beat_data.push_back(8'h04);
    run_burst(1, 14, 3, 8'hFF);
    run_burst(0, 14, 3, 8'h00);

    // Masked write over a cleared word.
    beat_data.push_back(8'h00);
    run_burst(1, 3, 0, 8'hFF);
    beat_data.push_back(8'hFF);
    run_burst(1, 3, 0, 8'h0F);
    run_burst(0, 3, 0, 8'h00);

    // ram_busy for 3 cycles during write beat 1, then during RD_ISSUE.
    fork
      run_burst(1, 6, 3, 8'hFF);
      begin
        repeat (2) @(posedge clk);
        #1 ram_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 ram_busy = 1'b0;
      end
    join
    a0 = n_access;
    fork
      run_burst(0, 6, 3, 8'h00);
      begin
        @(posedge clk);
        #1 ram_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 ram_busy = 1'b0;
      end
    join
    check("stalled_read_accesses", n_access - a0, 4);

    // Full-depth bursts.
    a0 = n_access;
    run_burst(1, 0, 15, 8'hFF);
    check("full_write_accesses", n_access - a0, 16);
    a0 = n_access;
    run_burst(0, 0, 15, 8'h00);
    check("full_read_accesses", n_access - a0, 16);

    // Reset at beat 2 of a 4-beat write: beats 0-1 land, 2-3 do not.
    d0 = done_seen;
    for (int i = 0; i < 2; i++) begin
      model_mem[8 + i] = DW'(8'h30 + i);
      exp_wr_q.push_back('{addr: AW'(8 + i), data: DW'(8'h30 + i), mask: 8'hFF});
    end
    cmd_handshake(1, 8, 3, 8'hFF);
    drive_beat(8'h30);
    drive_beat(8'h31);
    wdata_valid = 1'b1;
    wdata       = 8'hC2;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_burst_reset_outputs");
    wdata_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);
    check("no_done_on_abort", done_seen, d0);
    check("abort_writes_consumed", exp_wr_q.size(), 0);
    @(posedge clk);
    #1;
    run_burst(0, 8, 3, 8'h00);

    // Randomised traffic with busy stalls, data gaps and read backpressure.
    busy_mode  = 1;
    rand_ready = 1;
    gaps       = 1;
    for (int k = 0; k < 30; k++) begin
      run_burst(1'($urandom_range(1)), $urandom_range(DEPTH - 1),
                ($urandom_range(3) == 0) ? $urandom_range(DEPTH - 1) : $urandom_range(3),
                DW'($urandom));
    end
    busy_mode = 0;
    ram_busy  = 1'b0;
    for (int i = 0; i < DEPTH; i += 4) run_burst(0, i, 3, 8'h00);

    repeat (3) @(posedge clk);
    check("exp_wr_empty", exp_wr_q.size(), 0);
    check("exp_rd_empty", exp_rd_q.size(), 0);
    check("exp_rd_addr_empty", exp_rd_addr_q.size(), 0);
    check("done_count", done_seen, n_cmds);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
